// File: rtl/tensor_core_scheduler.sv
// Round-robin scheduler sharing one SIZE x SIZE tensor core (D = A*B + C) among NUM_REQ requesters.
// Define TC_SCHED_PERF_CNT_EN to add the perf_ops / perf_stall counters.
module tensor_core_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int SIZE       = 4,
  parameter int TIMEOUT    = 64,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_REQ-1:0]                        req_valid,
  output logic [NUM_REQ-1:0]                        req_ready,
  input  logic [NUM_REQ*8-1:0]                      req_opcode,
  input  logic [NUM_REQ*SIZE*SIZE*DATA_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*SIZE*SIZE*DATA_WIDTH-1:0]   req_b,
  input  logic [NUM_REQ*SIZE*SIZE*ACC_WIDTH-1:0]    req_c,
  output logic                                      tc_valid_in,
  output logic [7:0]                                tc_opcode,
  output logic [SIZE*SIZE*DATA_WIDTH-1:0]           tc_a,
  output logic [SIZE*SIZE*DATA_WIDTH-1:0]           tc_b,
  output logic [SIZE*SIZE*ACC_WIDTH-1:0]            tc_c,
  input  logic                                      tc_valid_out,
  input  logic [SIZE*SIZE*ACC_WIDTH-1:0]            tc_d,
  output logic                                      rsp_valid,
  input  logic                                      rsp_ready,
  output logic [ID_W-1:0]                           rsp_id,
  output logic [SIZE*SIZE*ACC_WIDTH-1:0]            rsp_d,
  output logic                                      busy,
  output logic                                      err_timeout,
  output logic [ID_W-1:0]                           err_id
`ifdef TC_SCHED_PERF_CNT_EN
  ,
  output logic [NUM_REQ*16-1:0]                     perf_ops,
  output logic [31:0]                               perf_stall
`endif
);

  localparam int AW    = SIZE*SIZE*DATA_WIDTH;
  localparam int CW    = SIZE*SIZE*ACC_WIDTH;
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT-1);
  localparam logic [ID_W:0]    NREQ_W   = (ID_W+1)'(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           state, state_nxt;
  logic [ID_W-1:0]  rr_ptr, own_id, winner, ptr_nxt;
  logic [ID_W:0]    cand;
  logic             found;
  logic [CNT_W-1:0] wait_cnt;
  logic             grant;

  // Round-robin search starting at rr_ptr, wrapping past NUM_REQ-1.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!found && req_valid[cand[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[ID_W-1:0];
      end
    end
    ptr_nxt = (int'(winner) == NUM_REQ-1) ? '0 : winner + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_ready   = '0;
    tc_valid_in = 1'b0;
    rsp_valid   = 1'b0;
    grant       = 1'b0;
    case (state)
      S_IDLE: begin
        // Gated by rst so no grant strobe is visible while held in reset.
        if (found && !rst) begin
          grant             = 1'b1;
          req_ready[winner] = 1'b1;
          state_nxt         = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tc_valid_in = 1'b1;
        state_nxt   = S_WAIT;
      end
      S_WAIT: begin
        if (tc_valid_out)              state_nxt = S_RESP;
        else if (wait_cnt == CNT_LAST) state_nxt = S_IDLE;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy   = (state != S_IDLE);
  assign rsp_id = own_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      own_id      <= '0;
      tc_opcode   <= '0;
      tc_a        <= '0;
      tc_b        <= '0;
      tc_c        <= '0;
      rsp_d       <= '0;
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
      err_id      <= '0;
    end else begin
      if (grant) begin
        tc_opcode <= req_opcode[int'(winner)*8 +: 8];
        tc_a      <= req_a[int'(winner)*AW +: AW];
        tc_b      <= req_b[int'(winner)*AW +: AW];
        tc_c      <= req_c[int'(winner)*CW +: CW];
        own_id    <= winner;
        rr_ptr    <= ptr_nxt;
      end
      if (state == S_ISSUE)     wait_cnt <= '0;
      else if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
      if (state == S_WAIT && tc_valid_out) rsp_d <= tc_d;
      // A result arriving on the last wait cycle takes priority over the abort.
      if (state == S_WAIT && !tc_valid_out && wait_cnt == CNT_LAST) begin
        err_timeout <= 1'b1;
        err_id      <= own_id;
      end
    end
  end

`ifdef TC_SCHED_PERF_CNT_EN
  logic stall_cyc;
  assign stall_cyc = busy ? (|req_valid) : ((|req_valid) && !found);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else begin
      if (rsp_valid && rsp_ready)
        perf_ops[int'(own_id)*16 +: 16] <= perf_ops[int'(own_id)*16 +: 16] + 16'd1;
      if (stall_cyc && perf_stall != 32'hFFFF_FFFF)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tensor_core_scheduler.sv
// Bench for tensor_core_scheduler: behavioural tensor core, grant-time scoreboard, directed scenarios.
module tb_tensor_core_scheduler;
  localparam int NR = 4, DW = 16, CW = 32, SZ = 4, NE = 16, TO = 64;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NR-1:0]        req_valid, req_ready;
  logic [NR*8-1:0]      req_opcode;
  logic [NR*NE*DW-1:0]  req_a, req_b;
  logic [NR*NE*CW-1:0]  req_c;
  logic                 tc_valid_in, tc_valid_out;
  logic [7:0]           tc_opcode;
  logic [NE*DW-1:0]     tc_a, tc_b;
  logic [NE*CW-1:0]     tc_c, tc_d, rsp_d;
  logic                 rsp_valid, rsp_ready, busy, err_timeout;
  logic [1:0]           rsp_id, err_id;

  logic signed [DW-1:0] a_m [NR][NE];
  logic signed [DW-1:0] b_m [NR][NE];
  logic signed [CW-1:0] c_m [NR][NE];
  logic [7:0]           opc [NR];

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  tensor_core_scheduler #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ACC_WIDTH(CW), .SIZE(SZ), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .tc_valid_in(tc_valid_in), .tc_opcode(tc_opcode), .tc_a(tc_a), .tc_b(tc_b), .tc_c(tc_c),
    .tc_valid_out(tc_valid_out), .tc_d(tc_d),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_d(rsp_d),
    .busy(busy), .err_timeout(err_timeout), .err_id(err_id)
  );

  always_comb begin
    req_a = '0; req_b = '0; req_c = '0; req_opcode = '0;
    for (int r = 0; r < NR; r++) begin
      req_opcode[r*8 +: 8] = opc[r];
      for (int k = 0; k < NE; k++) begin
        req_a[(r*NE+k)*DW +: DW] = a_m[r][k];
        req_b[(r*NE+k)*DW +: DW] = b_m[r][k];
        req_c[(r*NE+k)*CW +: CW] = c_m[r][k];
      end
    end
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NE*CW-1:0] core_mul(input logic [NE*DW-1:0] a, input logic [NE*DW-1:0] b,
                                                input logic [NE*CW-1:0] c);
    logic [NE*CW-1:0] d;
    logic signed [63:0] s;
    d = '0;
    for (int i = 0; i < SZ; i++)
      for (int j = 0; j < SZ; j++) begin
        s = 64'($signed(c[(i*SZ+j)*CW +: CW]));
        for (int k = 0; k < SZ; k++)
          s = s + 64'($signed(a[(i*SZ+k)*DW +: DW])) * 64'($signed(b[(k*SZ+j)*DW +: DW]));
        d[(i*SZ+j)*CW +: CW] = s[31:0];
      end
    return d;
  endfunction

  function automatic logic [NE*CW-1:0] golden(input int r);
    logic [NE*CW-1:0] d;
    logic signed [63:0] s;
    d = '0;
    for (int i = 0; i < SZ; i++)
      for (int j = 0; j < SZ; j++) begin
        s = 64'(c_m[r][i*SZ+j]);
        for (int k = 0; k < SZ; k++)
          s = s + 64'(a_m[r][i*SZ+k]) * 64'(b_m[r][k*SZ+j]);
        d[(i*SZ+j)*CW +: CW] = s[31:0];
      end
    return d;
  endfunction

  function automatic int enc(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Behavioural core: result appears core_lat cycles after the tc_valid_in pulse.
  int               core_lat = 3;
  bit               core_en  = 1'b1;
  bit               spur     = 1'b0;
  int               cd;
  logic             vo_m;
  logic [NE*CW-1:0] pend;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cd <= 0; vo_m <= 1'b0; tc_d <= '0; pend <= '0;
    end else begin
      vo_m <= 1'b0;
      if (cd == 1) begin vo_m <= 1'b1; tc_d <= pend; end
      if (cd > 0) cd <= cd - 1;
      if (tc_valid_in && core_en) begin
        cd   <= core_lat - 1;
        pend <= core_mul(tc_a, tc_b, tc_c);
      end
    end
  end
  assign tc_valid_out = vo_m | spur;

  typedef struct { logic [1:0] id; logic [NE*CW-1:0] d; } exp_t;
  exp_t sb[$];
  exp_t e_m;

  always @(negedge clk) begin
    if (!rst) begin
      if (req_ready != '0) begin
        check("grant_onehot", 32'($countones(req_ready)), 1);
        check("grant_requested", req_ready & ~req_valid, 0);
        sb.push_back('{2'(enc(req_ready)), golden(enc(req_ready))});
      end
      if (rsp_valid && rsp_ready) begin
        check("rsp_expected", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e_m = sb.pop_front();
          check("sb_rsp_id", rsp_id, e_m.id);
          check("sb_rsp_d", rsp_d, e_m.d);
        end
      end
    end
  end

  task automatic wait_grant(output int id);
    bit got = 1'b0;
    id = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        id  = enc(req_ready);
        got = 1'b1;
        break;
      end
    end
    check("grant_seen", got, 1);
  endtask

  task automatic wait_rsp();
    bit got = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1'b1; break; end
    end
    check("rsp_seen", got, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int id, n;
    bit saw;
    int av[NE] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 1, 2, 3, 4, 5, 6, 7};
    int rr_exp[5] = '{0, 1, 2, 3, 0};
    logic [NE*CW-1:0] exp_a32;
    logic [NE*DW-1:0] exp_a16;

    for (int r = 0; r < NR; r++) begin
      opc[r] = 8'($urandom);
      for (int k = 0; k < NE; k++) begin
        a_m[r][k] = DW'($urandom);
        b_m[r][k] = DW'($urandom);
        c_m[r][k] = CW'($urandom);
      end
    end
    exp_a32 = '0; exp_a16 = '0;
    for (int k = 0; k < NE; k++) begin
      a_m[0][k] = DW'(av[k]);
      b_m[0][k] = (k % 5 == 0) ? 16'sd1 : 16'sd0;
      c_m[0][k] = '0;
      exp_a32[k*CW +: CW] = CW'(av[k]);
      exp_a16[k*DW +: DW] = DW'(av[k]);
    end
    opc[0] = 8'h5A;

    // Reset state, with requests pending during reset
    rst = 1'b1; req_valid = 4'hF; rsp_ready = 1'b1;
    #12;
    check("rst_req_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_tc_valid_in", tc_valid_in, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_err_id", err_id, 0);
    check("rst_tc_a", tc_a, 0);
    check("rst_rsp_d", rsp_d, 0);
    req_valid = '0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Single request, identity B: result equals A
    req_valid = 4'b0001;
    wait_grant(id);
    check("t1_grant", id, 0);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    @(negedge clk);
    check("t1_vin_pulse", tc_valid_in, 1);
    check("t1_busy", busy, 1);
    check("t1_tc_a", tc_a, exp_a16);
    check("t1_tc_opcode", tc_opcode, 8'h5A);
    @(negedge clk);
    check("t1_vin_single", tc_valid_in, 0);
    n = 2;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    check("t1_latency", n, 5);
    check("t1_rsp_id", rsp_id, 0);
    check("t1_rsp_d", rsp_d, exp_a32);
    @(posedge clk); #1;

    // Round-robin with all four requesting, starting from a fresh pointer
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    req_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      wait_grant(id);
      check("rr_order", id, rr_exp[i]);
      @(negedge clk);
      check("rr_ready_pulse", req_ready, 0);
    end
    @(posedge clk); #1 req_valid = '0;
    wait_rsp();
    @(posedge clk); #1;

    // Wrap-around: after req2 the pointer sits at 3
    req_valid = 4'b0100;
    wait_grant(id);
    check("wrap_first", id, 2);
    @(posedge clk); #1 req_valid = '0;
    wait_rsp();
    @(posedge clk); #1 req_valid = 4'b1001;
    wait_grant(id);
    check("wrap_req3", id, 3);
    @(posedge clk); #1 req_valid[3] = 1'b0;
    wait_grant(id);
    check("wrap_req0", id, 0);
    @(posedge clk); #1 req_valid = '0;
    wait_rsp();
    @(posedge clk); #1;

    // Backpressure: response held while rsp_ready is low
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    wait_grant(id);
    check("bp_grant", id, 1);
    @(posedge clk); #1 req_valid = 4'b0100;
    wait_rsp();
    for (int i = 0; i < 10; i++) begin
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_id", rsp_id, 1);
      check("bp_rsp_d", rsp_d, golden(1));
      check("bp_no_grant", req_ready, 0);
      check("bp_no_vin", tc_valid_in, 0);
      @(negedge clk);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_cycle", rsp_valid, 1);
    @(negedge clk);
    check("bp_next_grant", req_ready, 4'b0100);
    @(posedge clk); #1 req_valid = '0;
    wait_rsp();
    @(posedge clk); #1;

    // Timeout: core never answers
    core_en = 1'b0;
    saw = 1'b0;
    req_valid = 4'b0010;
    wait_grant(id);
    check("to_grant", id, 1);
    @(posedge clk); #1 req_valid = '0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (rsp_valid) saw = 1'b1;
    end
    @(negedge clk);
    check("to_last_wait_err", err_timeout, 0);
    check("to_last_wait_busy", busy, 1);
    @(negedge clk);
    check("to_err_timeout", err_timeout, 1);
    check("to_err_id", err_id, 1);
    check("to_idle", busy, 0);
    check("to_no_rsp_now", rsp_valid, 0);
    check("to_no_rsp_ever", saw, 0);
    check("to_sb_pending", sb.size(), 1);
    if (sb.size() > 0) void'(sb.pop_front());
    @(posedge clk); #1 spur = 1'b1;
    @(posedge clk); #1 spur = 1'b0;
    @(negedge clk);
    check("spur_busy", busy, 0);
    check("spur_rsp_valid", rsp_valid, 0);
    check("spur_err_sticky", err_timeout, 1);
    core_en = 1'b1;

    // Async reset while waiting on the core
    core_lat = 20;
    req_valid = 4'b0100;
    wait_grant(id);
    check("ar_grant", id, 2);
    @(posedge clk); #1 req_valid = '0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("ar_busy", busy, 0);
    check("ar_tc_valid_in", tc_valid_in, 0);
    check("ar_rsp_valid", rsp_valid, 0);
    check("ar_err_timeout", err_timeout, 0);
    sb.delete();
    core_lat = 3;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1 req_valid = 4'b1001;
    wait_grant(id);
    check("ar_first_grant", id, 0);
    @(posedge clk); #1 req_valid = '0;
    wait_rsp();
    @(posedge clk); #1;
    @(negedge clk);
    check("final_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tensor_core_scheduler.md
Name: tensor_core_scheduler

Overview:
- Shares one tensor_core (D = A*B + C, SIZE x SIZE) among NUM_REQ requesters, such as warp slots in an SM.
- Arbitrates round-robin and latches the winner's operands and opcode.
- Drives the core's valid_in/opcode, waits for valid_out, and returns matrix_d tagged with the requester ID.
- Only one operation is in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_WIDTH, 16, A/B element width (signed).
- ACC_WIDTH, 32, C/D element width (signed).
- SIZE, 4, matrix dimension.
- TIMEOUT, 64, max WAIT cycles before abort (>=2).
- ID_W, $clog2(NUM_REQ), requester ID width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  NUM_REQ  per-requester request
- req_ready  out  NUM_REQ  one-hot grant, accept strobe
- req_opcode  in  NUM_REQ*8  per-requester opcode
- req_a  in  NUM_REQ*SIZE*SIZE*DATA_WIDTH  flattened A, row-major, element [i][j] at index (i*SIZE+j)
- req_b  in  NUM_REQ*SIZE*SIZE*DATA_WIDTH  flattened B
- req_c  in  NUM_REQ*SIZE*SIZE*ACC_WIDTH  flattened C
- tc_valid_in  out  1  start pulse to core
- tc_opcode  out  8  latched opcode
- tc_a/tc_b  out  SIZE*SIZE*DATA_WIDTH  latched operands
- tc_c  out  SIZE*SIZE*ACC_WIDTH  latched accumulator
- tc_valid_out  in  1  core result valid
- tc_d  in  SIZE*SIZE*ACC_WIDTH  core result
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  ID_W  owning requester
- rsp_d  out  SIZE*SIZE*ACC_WIDTH  captured result
- busy  out  1  state != IDLE
- err_timeout  out  1  sticky timeout flag
- err_id  out  ID_W  requester of the last timed-out op

Behaviour:
- Reset:
  - All outputs 0; state IDLE; rr_ptr=0; wait counter 0; operand/result registers 0.
  - Reset mid-operation aborts the operation immediately, and no response is produced.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner = first asserted req_valid searching from rr_ptr upward with wrap-around.
  - req_ready[winner]=1 combinationally in that same cycle only.
  - On the edge: latch that requester's opcode/A/B/C and ID; rr_ptr <= winner+1 mod NUM_REQ; go to ISSUE.
  - No request: stay in IDLE, req_ready all 0.
- ISSUE: tc_valid_in=1 for exactly one cycle; clear the wait counter; go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - tc_valid_out=1: capture tc_d into rsp_d; go to RESP.
  - Counter reaches TIMEOUT-1 without valid_out: set err_timeout=1 and err_id=latched ID; go to IDLE; no response.
  - tc_valid_out and timeout in the same cycle: valid_out wins.
- RESP:
  - rsp_valid=1 and rsp_id/rsp_d stable until rsp_ready=1; the handshake returns the FSM to IDLE.
  - Backpressure is unbounded, with no timeout in RESP.
- tc_valid_out outside WAIT is ignored (no capture, no state change).
- tc_a/b/c/opcode hold their latched values from grant until the next grant.
- Latency: request granted in cycle T → tc_valid_in at T+1 → rsp_valid at (valid_out cycle)+1 → next grant no earlier than the cycle after the rsp handshake.
- Fairness: a continuously requesting port waits at most NUM_REQ-1 operations.
- err_timeout clears only on rst.

Optional Feature:
- Macro: TC_SCHED_PERF_CNT_EN.
- When defined:
  - Adds output perf_ops, NUM_REQ*16 bits: per-requester 16-bit completed-op counters, incremented on each rsp handshake for rsp_id, wrapping at 0xFFFF→0.
  - Adds output perf_stall, 32 bits: counts cycles in IDLE with any req_valid=1 that is not granted (always 0 in this FSM), plus cycles in ISSUE/WAIT/RESP with any req_valid=1. Saturates at 0xFFFFFFFF.
  - Both reset to 0.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Single request:
  - Stimulus: req0 with A=[[1,2,3,4],[5,6,7,8],[9,1,2,3],[4,5,6,7]], B=identity, C=0; core model latency 3.
  - Required: rsp_valid with rsp_id=0 and rsp_d=A; tc_valid_in is a single pulse at T+1.
- Round-robin:
  - Stimulus: all four req_valid held high, rsp_ready=1.
  - Required: grant order 0,1,2,3,0; each grant one-hot with a single-cycle req_ready.
- Wrap-around:
  - Stimulus: rr_ptr=3 after granting req2, with req0 and req3 pending.
  - Required: req3 granted first, then req0.
- Backpressure:
  - Stimulus: rsp_ready=0 for 10 cycles after rsp_valid.
  - Required: rsp_d/rsp_id stable, no new grant, tc_valid_in stays 0; after rsp_ready=1 the next grant comes one cycle later.
- Timeout:
  - Stimulus: core model never asserts valid_out, TIMEOUT=64, req1.
  - Required: after 64 WAIT cycles err_timeout=1, err_id=1, FSM back in IDLE, no rsp_valid; a later spurious tc_valid_out is ignored.
- Async reset in WAIT:
  - Stimulus: assert rst mid-operation.
  - Required: busy, tc_valid_in, rsp_valid and err_timeout go 0 immediately; the first grant after release goes to req0.
